// File: rtl/rx_frame_capture.sv
// rx_frame_capture
//   Captures NTS-classified frames from the RX preprocessor word stream into a
//   single-frame buffer. A frame is committed only on a clean MAC good strobe.
//   Everything else is dropped and counted. A committed frame is held until the
//   consumer releases it. The held frame is read through a 1-cycle-latency port.
// Ports:
//   i_clk, i_areset          clock, asynchronous active-high reset
//   i_rx_data_be/valid4bit   big-endian frame word and its valid byte count
//   i_sof, i_packet_*        start of frame and its classification
//   i_ethernet_good/bad      MAC frame status strobes
//   o_frame_available/words/bytes, i_frame_release   hold/release handshake
//   i_rd_en/addr, o_rd_data/valid                     buffer read port
//   o_cnt_*                  wrapping 32-bit event counters
module rx_frame_capture #(
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  i_clk,
  input  logic                  i_areset,
  input  logic [63:0]           i_rx_data_be,
  input  logic [3:0]            i_rx_valid4bit,
  input  logic                  i_sof,
  input  logic                  i_packet_nts,
  input  logic                  i_packet_other,
  input  logic                  i_packet_drop,
  input  logic                  i_ethernet_good,
  input  logic                  i_ethernet_bad,
  output logic                  o_frame_available,
  output logic [ADDR_WIDTH:0]   o_frame_words,
  output logic [ADDR_WIDTH+3:0] o_frame_bytes,
  input  logic                  i_frame_release,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [63:0]           o_rd_data,
  output logic                  o_rd_valid,
  output logic [31:0]           o_cnt_accepted,
  output logic [31:0]           o_cnt_busy,
  output logic [31:0]           o_cnt_bad,
  output logic [31:0]           o_cnt_drop,
  output logic [31:0]           o_cnt_other
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_WORDS = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    RECEIVE     = 2'd1,
    WAIT_STATUS = 2'd2,
    READY       = 2'd3
  } state_t;

  state_t                state_r;
  logic [ADDR_WIDTH:0]   word_cnt_r;
  logic [ADDR_WIDTH+3:0] byte_cnt_r;
  logic                  overflow_r;
  logic                  frame_available_r;
  logic [ADDR_WIDTH:0]   frame_words_r;
  logic [ADDR_WIDTH+3:0] frame_bytes_r;
  logic [31:0]           cnt_accepted_r, cnt_busy_r, cnt_bad_r, cnt_drop_r, cnt_other_r;
  logic [63:0]           mem_r [DEPTH];
  logic [63:0]           rd_data_r;
  logic                  rd_valid_r;

  logic                  in_frame_s, start_s, data_s, short_s, status_s;
  logic                  commit_s, inc_bad_s, wr_en_s, ovf_nxt_s;
  logic [ADDR_WIDTH-1:0] wr_addr_s;
  logic [ADDR_WIDTH:0]   word_nxt_s;
  logic [ADDR_WIDTH+3:0] byte_nxt_s, valid_ext_s;

  assign in_frame_s  = (state_r == RECEIVE) || (state_r == WAIT_STATUS);
  // A new NTS sof restarts capture from any state except READY (abort is implicit).
  assign start_s     = i_sof && i_packet_nts && (state_r != READY);
  assign data_s      = (state_r == RECEIVE) && !i_sof && (i_rx_valid4bit != 4'd0);
  assign short_s     = (i_rx_valid4bit < 4'd8);
  // Status strobes on a sof cycle belong to the aborted frame and are ignored.
  assign status_s    = in_frame_s && !i_sof;
  assign valid_ext_s = {{ADDR_WIDTH{1'b0}}, i_rx_valid4bit};

  // Next word/byte counts, overflow flag and buffer write strobe.
  always_comb begin
    wr_en_s    = 1'b0;
    wr_addr_s  = '0;
    word_nxt_s = word_cnt_r;
    byte_nxt_s = byte_cnt_r;
    ovf_nxt_s  = overflow_r;
    if (start_s) begin
      wr_en_s    = 1'b1;
      word_nxt_s = {{ADDR_WIDTH{1'b0}}, 1'b1};
      byte_nxt_s = valid_ext_s;
      ovf_nxt_s  = 1'b0;
    end else if (data_s) begin
      // Counts saturate at a full buffer, which bounds the byte count width.
      if (word_cnt_r == FULL_WORDS) begin
        ovf_nxt_s = 1'b1;
      end else begin
        wr_en_s    = 1'b1;
        wr_addr_s  = word_cnt_r[ADDR_WIDTH-1:0];
        word_nxt_s = word_cnt_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
        byte_nxt_s = byte_cnt_r + valid_ext_s;
      end
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Commit and drop decisions; the current cycle's word and overflow are included.
  always_comb begin
    commit_s  = status_s && i_ethernet_good && !i_ethernet_bad && !ovf_nxt_s;
    inc_bad_s = (i_sof && in_frame_s) ||
                (status_s && (i_ethernet_bad || (i_ethernet_good && ovf_nxt_s)));
  end

  // Frame buffer write port (no reset so it maps onto RAM).
  always_ff @(posedge i_clk) begin
    if (wr_en_s) begin
      mem_r[wr_addr_s] <= i_rx_data_be;
    end
  end

  // Registered 1-cycle-latency read port.
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      rd_data_r  <= 64'd0;
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= i_rd_en;
      if (i_rd_en) begin
        rd_data_r <= mem_r[i_rd_addr];
      end else begin
        rd_data_r <= rd_data_r;
      end
    end
  end

  // Capture state machine with running counts and held-frame length outputs.
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      state_r           <= IDLE;
      word_cnt_r        <= '0;
      byte_cnt_r        <= '0;
      overflow_r        <= 1'b0;
      frame_available_r <= 1'b0;
      frame_words_r     <= '0;
      frame_bytes_r     <= '0;
    end else begin
      word_cnt_r <= word_nxt_s;
      byte_cnt_r <= byte_nxt_s;
      overflow_r <= ovf_nxt_s;
      case (state_r)
        IDLE, RECEIVE, WAIT_STATUS: begin
          if (start_s) begin
            state_r <= short_s ? WAIT_STATUS : RECEIVE;
          end else if (i_sof || (state_r == IDLE)) begin
            state_r <= IDLE;
          end else if (commit_s) begin
            state_r           <= READY;
            frame_available_r <= 1'b1;
            frame_words_r     <= word_nxt_s;
            frame_bytes_r     <= byte_nxt_s;
          end else if (i_ethernet_good || i_ethernet_bad) begin
            state_r <= IDLE;
          end else if ((state_r == RECEIVE) && short_s) begin
            state_r <= WAIT_STATUS;
          end else begin
            state_r <= state_r;
          end
        end
        READY: begin
          // An NTS sof arriving now is counted busy and otherwise ignored.
          if (i_frame_release) begin
            state_r           <= IDLE;
            frame_available_r <= 1'b0;
          end else begin
            state_r <= READY;
          end
        end
        default: begin
          state_r           <= IDLE;
          frame_available_r <= 1'b0;
        end
      endcase
    end
  end

  // Wrapping event counters.
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      cnt_accepted_r <= 32'd0;
      cnt_busy_r     <= 32'd0;
      cnt_bad_r      <= 32'd0;
      cnt_drop_r     <= 32'd0;
      cnt_other_r    <= 32'd0;
    end else begin
      if (commit_s)                                      cnt_accepted_r <= cnt_accepted_r + 32'd1;
      if (i_sof && i_packet_nts && (state_r == READY))   cnt_busy_r     <= cnt_busy_r + 32'd1;
      if (inc_bad_s)                                     cnt_bad_r      <= cnt_bad_r + 32'd1;
      if (i_sof && i_packet_drop)                        cnt_drop_r     <= cnt_drop_r + 32'd1;
      if (i_sof && i_packet_other)                       cnt_other_r    <= cnt_other_r + 32'd1;
    end
  end

  assign o_frame_available = frame_available_r;
  assign o_frame_words     = frame_words_r;
  assign o_frame_bytes     = frame_bytes_r;
  assign o_rd_data         = rd_data_r;
  assign o_rd_valid        = rd_valid_r;
  assign o_cnt_accepted    = cnt_accepted_r;
  assign o_cnt_busy        = cnt_busy_r;
  assign o_cnt_bad         = cnt_bad_r;
  assign o_cnt_drop        = cnt_drop_r;
  assign o_cnt_other       = cnt_other_r;

endmodule

// File: doc/rx_frame_capture.md
Name: rx_frame_capture

Overview:
- Sits directly downstream of the RX preprocessor and consumes its big-endian word stream and per-frame classification flags.
- Captures frames flagged NTS into a single-frame word buffer.
- Commits a captured frame only when the MAC reports it good; all other frames are discarded and counted.
- Presents a committed frame to the NTS dispatcher through a hold/release handshake and a 1-cycle-latency read port.

Parameters:
- ADDR_WIDTH, 7, log2 of buffer depth in 64-bit words (default 128 words = 1024 bytes).

Ports:
- i_clk  in  1  clock
- i_areset  in  1  asynchronous active-high reset
- i_rx_data_be  in  64  frame word, big-endian, unused low bytes zero
- i_rx_valid4bit  in  4  valid byte count of i_rx_data_be, 0..8
- i_sof  in  1  first word of frame this cycle
- i_packet_nts  in  1  classification, meaningful only with i_sof
- i_packet_other  in  1  classification, meaningful only with i_sof
- i_packet_drop  in  1  classification, meaningful only with i_sof
- i_ethernet_good  in  1  MAC good-frame strobe
- i_ethernet_bad  in  1  MAC bad-frame strobe
- o_frame_available  out  1  committed frame held in buffer
- o_frame_words  out  ADDR_WIDTH+1  words in held frame
- o_frame_bytes  out  ADDR_WIDTH+4  bytes in held frame
- i_frame_release  in  1  consumer done with held frame
- i_rd_en  in  1  read request
- i_rd_addr  in  ADDR_WIDTH  word address
- o_rd_data  out  64  read data
- o_rd_valid  out  1  o_rd_data valid
- o_cnt_accepted  out  32  frames committed
- o_cnt_busy  out  32  NTS frames dropped because the buffer was occupied
- o_cnt_bad  out  32  NTS frames dropped: MAC bad, overflow, or truncated by a new sof
- o_cnt_drop  out  32  frames flagged i_packet_drop
- o_cnt_other  out  32  frames flagged i_packet_other

Behaviour:
- Reset: every output is 0 and the state is IDLE. Reset mid-frame or mid-hold loses the frame and does not count it.
- States: IDLE, RECEIVE, WAIT_STATUS, READY.
- Frame start (i_sof=1):
  - i_packet_drop increments cnt_drop; i_packet_other increments cnt_other.
  - i_packet_nts in IDLE: write the word at address 0, set byte_count = i_rx_valid4bit and word_count = 1, then go to RECEIVE.
  - If i_rx_valid4bit<8 on the sof word, it is also the last word and the next state is WAIT_STATUS.
  - i_packet_nts in READY increments cnt_busy; the frame is ignored, even if i_frame_release is asserted in the same cycle.
  - i_sof in RECEIVE or WAIT_STATUS aborts the current frame and increments cnt_bad. The new sof is then handled as if the state were IDLE.
- RECEIVE, per cycle with i_rx_valid4bit>0:
  - Write the word at address word_count[ADDR_WIDTH-1:0].
  - word_count += 1; byte_count += i_rx_valid4bit.
  - If word_count was already 2^ADDR_WIDTH, do not write and set the sticky overflow flag.
- End of data: a cycle with i_rx_valid4bit<8 ends data. A zero-valid cycle writes nothing. The next state is WAIT_STATUS.
- MAC status, sampled in RECEIVE or WAIT_STATUS, including the last-word cycle:
  - i_ethernet_bad, or good and bad together: go to IDLE and increment cnt_bad.
  - i_ethernet_good alone, overflow clear: go to READY, increment cnt_accepted, latch o_frame_words and o_frame_bytes.
  - i_ethernet_good alone, overflow set: go to IDLE and increment cnt_bad.
  - Good arriving in RECEIVE ends the frame. A word present in that cycle is still captured.
- Status strobes in IDLE or READY are ignored.
- READY:
  - o_frame_available=1. Buffer contents and length outputs are stable.
  - i_frame_release → IDLE next cycle. o_frame_available falls in that cycle; the length outputs hold their values until the next commit.
- Read port:
  - i_rd_en at cycle N → o_rd_data and o_rd_valid at N+1.
  - Reads are legal in any state; data is defined only in READY.
- Counters wrap modulo 2^32.
- Byte count arithmetic never exceeds ADDR_WIDTH+4 bits, because the word count saturates at the overflow point.

Test Plan:
- 90-byte IPv4 NTS frame: 11 full words plus a last word of valid=2, good on the last word → o_frame_available=1, words=12, bytes=90, cnt_accepted=1. Reading addr 0 and 11 returns the injected words 1 cycle later.
- Same frame with i_ethernet_bad 3 cycles after the last word → IDLE, o_frame_available=0, cnt_bad=1, cnt_accepted=0.
- Frame held in READY, second NTS sof arrives with i_frame_release in the same cycle → cnt_busy=1. The first frame's length is unchanged until the next commit, and the state is IDLE the next cycle.
- ADDR_WIDTH=4, 17 full words plus valid=0, then good → no commit, cnt_bad=1, buffer words 0..15 not corrupted by the 17th.
- sof with i_packet_other, then sof with i_packet_drop, each followed by good → cnt_other=1, cnt_drop=1, no capture, o_frame_available=0.
- NTS frame, i_areset pulsed in word 5, then a clean 90-byte NTS frame → all counters restart and end with cnt_accepted=1, bytes=90.
